lbp_writer: RTL

- Write-side counterpart of the gray-pixel read path in the 2016 LBP design.
- Consumes the tagged gray-sample stream (centre, then 8 neighbours) returned for each pixel of the 128x128 image, computes the 8-bit LBP code, and issues one write per pixel to the LBP memory.
- Border pixels are written as 0.
- Raises finish after the last pixel address has been written.

---
 rtl/lbp_writer.sv | 109 ++++++++++
 1 files changed

// File: rtl/lbp_writer.sv
// lbp_writer: turns the tagged centre+8-neighbour gray stream into one LBP memory write per pixel.
// Optional macro LBP_WCNT_EN adds wcnt_o, a saturating count of issued writes.
module lbp_writer #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 8,
   parameter int LAST_ADDR = 16383
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid_i,
   input  logic [3:0]        sample_idx_i,
   input  logic [DATA_W-1:0] sample_data_i,
   input  logic [ADDR_W-1:0] pix_addr_i,
   input  logic              border_i,
   output logic              lbp_valid_o,
   output logic [ADDR_W-1:0] lbp_addr_o,
   output logic [DATA_W-1:0] lbp_data_o,
`ifdef LBP_WCNT_EN
   output logic [ADDR_W:0]   wcnt_o,
`endif
   output logic              finish_o,
   output logic              err_o
);
   typedef enum logic {COLLECT, DONE} state_t;
   state_t            state_q, state_d;
   logic [3:0]        exp_q, exp_d;
   logic [7:0]        code_q, code_d;
   logic [DATA_W-1:0] centre_q, centre_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic              last_wr;
   assign last_wr     = valid_q && (addr_q == ADDR_W'(LAST_ADDR));
   assign lbp_valid_o = valid_q;
   assign lbp_addr_o  = addr_q;
   assign lbp_data_o  = data_q;
   assign err_o       = err_q;
   assign finish_o    = (state_q == DONE);
   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         exp_q    <= '0;
         code_q   <= '0;
         centre_q <= '0;
         valid_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         code_q   <= code_d;
         centre_q <= centre_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end
   // Sample sequencing, code accumulation and write issue; the last write closes the image
   // in the same cycle it is strobed, so nothing arriving alongside it is accepted.
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      code_d   = code_q;
      centre_d = centre_q;
      valid_d  = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = err_q;
      if (last_wr) state_d = DONE;
      if (state_q == COLLECT && !last_wr && sample_valid_i) begin
         if (border_i) begin
            valid_d = 1'b1;
            addr_d  = pix_addr_i;
            data_d  = '0;
            exp_d   = '0;
         end else if (sample_idx_i != exp_q) begin
            err_d    = 1'b1;
            code_d   = '0;
            exp_d    = (sample_idx_i == 4'd0) ? 4'd1 : 4'd0;
            centre_d = (sample_idx_i == 4'd0) ? sample_data_i : centre_q;
         end else if (sample_idx_i == 4'd0) begin
            centre_d = sample_data_i;
            code_d   = '0;
            exp_d    = 4'd1;
         end else begin
            code_d[3'(sample_idx_i - 4'd1)] = (sample_data_i >= centre_q);
            exp_d = (sample_idx_i == 4'd8) ? 4'd0 : sample_idx_i + 4'd1;
            if (sample_idx_i == 4'd8) begin
               valid_d = 1'b1;
               addr_d  = pix_addr_i;
               data_d  = DATA_W'(code_d);
            end
         end
      end
   end
`ifdef LBP_WCNT_EN
   logic [ADDR_W:0] wcnt_q;
   assign wcnt_o = wcnt_q;
   // Saturating count of write strobes; stops once the image is done.
   always_ff @(posedge clk) begin
      if (rst) wcnt_q <= '0;
      else if (valid_q && state_q == COLLECT && wcnt_q != {1'b1, {ADDR_W{1'b0}}}) wcnt_q <= wcnt_q + 1'b1;
   end
`endif
endmodule
